// File: rtl/turbo_pair_packer.sv
// Packs 2-bit natural-order and deinterleaved pairs into byte pairs for one
// turbo PB frame, buffering them in a small output FIFO with valid/ready drain.
module turbo_pair_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] pb_size,
  input  logic       in_vld,
  input  logic [1:0] in_sys,
  input  logic [1:0] in_ditl,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic [7:0] out_sys,
  output logic [7:0] out_ditl,
  output logic       out_last,
  output logic       busy,
  output logic       ovf_err,
  output logic       cfg_err,
  output logic [1:0] dbg_state
);

  // Output handshake: a byte pair transfers on every rising edge where
  // out_vld and out_rdy are both high; the head is held while out_rdy is low.

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_target;
  logic [9:0]  r_byte_cnt;
  logic [1:0]  r_pair_cnt;
  logic [5:0]  r_sys_sh;
  logic [5:0]  r_ditl_sh;
  logic        r_ovf_err;
  logic        r_cfg_err;

  logic [16:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_byte_done;
  logic        w_is_last;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf;
  logic [7:0]  w_sys_byte;
  logic [7:0]  w_ditl_byte;
  logic [9:0]  w_target;
  logic [AW:0] w_count_next;

  assign w_byte_done = (r_state == ST_RUN) && in_vld && (r_pair_cnt == 2'd3);
  assign w_is_last   = (r_byte_cnt == (r_target - 10'd1));
  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = (r_count != '0) && out_rdy;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign w_push      = w_byte_done && (!w_full || w_pop);
  assign w_ovf       = w_byte_done && w_full && !w_pop;
  assign w_sys_byte  = {r_sys_sh, in_sys};
  assign w_ditl_byte = {r_ditl_sh, in_ditl};

  always_comb begin
    w_target = 10'd16;
    case (pb_size)
      2'd1:    w_target = 10'd136;
      2'd2:    w_target = 10'd520;
      default: w_target = 10'd16;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop)
      w_count_next = r_count - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_sys_byte, w_ditl_byte, w_is_last};
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_byte_cnt <= '0;
      r_pair_cnt <= '0;
      r_sys_sh   <= '0;
      r_ditl_sh  <= '0;
      r_ovf_err  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      if (w_ovf) r_ovf_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (pb_size == 2'd3) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_target   <= w_target;
              r_byte_cnt <= '0;
              r_pair_cnt <= '0;
              r_sys_sh   <= '0;
              r_ditl_sh  <= '0;
              r_state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (in_vld) begin
            r_sys_sh   <= {r_sys_sh[3:0], in_sys};
            r_ditl_sh  <= {r_ditl_sh[3:0], in_ditl};
            r_pair_cnt <= r_pair_cnt + 2'd1;
            // Dropped bytes still count so the frame ends on schedule.
            if (w_byte_done) begin
              r_byte_cnt <= r_byte_cnt + 10'd1;
              if (w_is_last) r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_count_next == '0) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_vld   = (r_count != '0);
  assign out_sys   = r_mem[r_rd_ptr][16:9];
  assign out_ditl  = r_mem[r_rd_ptr][8:1];
  assign out_last  = r_mem[r_rd_ptr][0];
  assign busy      = (r_state != ST_IDLE);
  assign ovf_err   = r_ovf_err;
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule
